// File: rtl/menu_input_ctrl_pkg.sv
// Shared definitions for the menu input controller: screen geometry, default button
// rectangles, link FSM encoding and a rectangle hit-test helper.
package menu_input_ctrl_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COORD_W  = $clog2((SCREEN_W > SCREEN_H) ? SCREEN_W : SCREEN_H);

  localparam int START_X0_DEF = 240;
  localparam int START_X1_DEF = 400;
  localparam int START_Y0_DEF = 240;
  localparam int START_Y1_DEF = 300;
  localparam int CONN_X0_DEF  = 240;
  localparam int CONN_X1_DEF  = 400;
  localparam int CONN_Y0_DEF  = 320;
  localparam int CONN_Y1_DEF  = 380;

  typedef enum logic [1:0] {
    LINK_IDLE   = 2'd0,
    LINK_REQ    = 2'd1,
    LINK_LINKED = 2'd2
  } link_state_e;

  // Left/top edges inclusive, right/bottom edges exclusive.
  function automatic logic in_rect(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y,
                                   input int x0, input int x1, input int y0, input int y1);
    int xi;
    int yi;
    xi = int'(x);
    yi = int'(y);
    return (xi >= x0) && (xi < x1) && (yi >= y0) && (yi < y1);
  endfunction

endpackage

// File: rtl/menu_input_ctrl_if.sv
// Menu screen signal bundle: mouse/enable/peer inputs towards the controller and the
// hover, link and start outputs back to the pixel generator and game FSM.
interface menu_input_ctrl_if;
  import menu_input_ctrl_pkg::*;

  logic               enable;
  logic [COORD_W-1:0] mouse_x;
  logic [COORD_W-1:0] mouse_y;
  logic               MOUSE_LEFT;
  logic               peer_connect_in;
  logic               mouse_on_start_button;
  logic               mouse_on_connect_button;
  logic               send_connect;
  logic               receive_connect;
  logic               peer_connect_out;
  logic               connected;
  logic               start_game;
  logic               start_multi;

  modport master (
    output enable, mouse_x, mouse_y, MOUSE_LEFT, peer_connect_in,
    input  mouse_on_start_button, mouse_on_connect_button, send_connect, receive_connect,
           peer_connect_out, connected, start_game, start_multi
  );

  modport slave (
    input  enable, mouse_x, mouse_y, MOUSE_LEFT, peer_connect_in,
    output mouse_on_start_button, mouse_on_connect_button, send_connect, receive_connect,
           peer_connect_out, connected, start_game, start_multi
  );

endinterface

// File: rtl/menu_input_ctrl_sync_debounce.sv
// Two-flop synchronizer followed by a stability filter: the output level follows the
// synced input only after it has disagreed for DEB_CYCLES consecutive cycles.
module menu_input_ctrl_sync_debounce #(
  parameter int DEB_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o
);

  localparam int CNT_W = $clog2(DEB_CYCLES);

  logic             meta_q;
  logic             sync_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any cycle of agreement restarts the count from zero.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= async_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/menu_input_ctrl.sv
// Menu input controller: registered button hover, press/release click detection,
// start pulse and the one-wire-each-way connect handshake with the peer board.
module menu_input_ctrl
  import menu_input_ctrl_pkg::*;
#(
  parameter int START_X0   = START_X0_DEF,
  parameter int START_X1   = START_X1_DEF,
  parameter int START_Y0   = START_Y0_DEF,
  parameter int START_Y1   = START_Y1_DEF,
  parameter int CONN_X0    = CONN_X0_DEF,
  parameter int CONN_X1    = CONN_X1_DEF,
  parameter int CONN_Y0    = CONN_Y0_DEF,
  parameter int CONN_Y1    = CONN_Y1_DEF,
  parameter int DEB_CYCLES = 1000
) (
  input logic         clk,
  input logic         rst,
  menu_input_ctrl_if.slave bus
);

  logic        on_start_q, on_start_d, on_conn_q, on_conn_d;
  logic        left_q, rise, fall;
  logic        arm_start_q, arm_start_d, arm_conn_q, arm_conn_d;
  logic        start_click_q, start_click_d, conn_click_q, conn_click_d;
  logic        start_multi_q, start_multi_d;
  logic        recv, connected;
  link_state_e state_q, state_d;

  menu_input_ctrl_sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_peer_deb (
    .clk    (clk),
    .rst    (rst),
    .async_i(bus.peer_connect_in),
    .level_o(recv)
  );

  assign on_start_d = bus.enable &&
      in_rect(bus.mouse_x, bus.mouse_y, START_X0, START_X1, START_Y0, START_Y1);
  assign on_conn_d  = bus.enable &&
      in_rect(bus.mouse_x, bus.mouse_y, CONN_X0, CONN_X1, CONN_Y0, CONN_Y1);

  assign rise = bus.MOUSE_LEFT && !left_q;
  assign fall = !bus.MOUSE_LEFT && left_q;

  // A click needs the press and the release both on the button with no excursion between.
  always_comb begin
    arm_start_d   = arm_start_q;
    arm_conn_d    = arm_conn_q;
    start_click_d = 1'b0;
    conn_click_d  = 1'b0;
    if (!bus.enable) begin
      arm_start_d = 1'b0;
      arm_conn_d  = 1'b0;
    end else begin
      if (rise && on_start_q) begin
        arm_start_d = 1'b1;
      end else if (!on_start_q) begin
        arm_start_d = 1'b0;
      end else if (fall && arm_start_q) begin
        arm_start_d   = 1'b0;
        start_click_d = 1'b1;
      end
      if (rise && on_conn_q) begin
        arm_conn_d = 1'b1;
      end else if (!on_conn_q) begin
        arm_conn_d = 1'b0;
      end else if (fall && arm_conn_q) begin
        arm_conn_d   = 1'b0;
        conn_click_d = 1'b1;
      end
    end
  end

  // A cancel click beats a simultaneous peer acknowledge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LINK_IDLE:   if (conn_click_q) state_d = LINK_REQ;
      LINK_REQ:    if (conn_click_q) state_d = LINK_IDLE;
                   else if (recv)    state_d = LINK_LINKED;
      LINK_LINKED: if (!recv)        state_d = LINK_REQ;
      default:     state_d = LINK_IDLE;
    endcase
  end

  assign connected     = (state_q == LINK_LINKED) && recv;
  assign start_multi_d = start_click_d ? connected : start_multi_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      on_start_q    <= 1'b0;
      on_conn_q     <= 1'b0;
      left_q        <= 1'b0;
      arm_start_q   <= 1'b0;
      arm_conn_q    <= 1'b0;
      start_click_q <= 1'b0;
      conn_click_q  <= 1'b0;
      start_multi_q <= 1'b0;
      state_q       <= LINK_IDLE;
    end else begin
      on_start_q    <= on_start_d;
      on_conn_q     <= on_conn_d;
      left_q        <= bus.MOUSE_LEFT;
      arm_start_q   <= arm_start_d;
      arm_conn_q    <= arm_conn_d;
      start_click_q <= start_click_d;
      conn_click_q  <= conn_click_d;
      start_multi_q <= start_multi_d;
      state_q       <= state_d;
    end
  end

  assign bus.mouse_on_start_button   = on_start_q;
  assign bus.mouse_on_connect_button = on_conn_q;
  assign bus.send_connect            = (state_q != LINK_IDLE);
  assign bus.peer_connect_out        = (state_q != LINK_IDLE);
  assign bus.receive_connect         = recv;
  assign bus.connected               = connected;
  assign bus.start_game              = start_click_q;
  assign bus.start_multi             = start_multi_q;

endmodule

// File: tb/tb_menu_input_ctrl.sv
// Bench for menu_input_ctrl: directed scenarios plus a randomized mouse run checked
// against a press/release window model of hover and click behaviour.
module tb_menu_input_ctrl;

  localparam int DEB = 16;
  localparam int NR  = 3000;
  localparam int SX0 = 240, SX1 = 400, SY0 = 240, SY1 = 300;
  localparam int CX0 = 240, CX1 = 400, CY0 = 320, CY1 = 380;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  menu_input_ctrl_if bus ();

  menu_input_ctrl #(.DEB_CYCLES(DEB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pos(input int x, input int y);
    bus.mouse_x = 10'(x);
    bus.mouse_y = 10'(y);
  endtask

  task automatic press_release();
    bus.MOUSE_LEFT = 1'b1;
    step();
    bus.MOUSE_LEFT = 1'b0;
    step();
  endtask

  function automatic logic [7:0] all_outs();
    return {bus.mouse_on_start_button, bus.mouse_on_connect_button, bus.send_connect,
            bus.receive_connect, bus.peer_connect_out, bus.connected, bus.start_game,
            bus.start_multi};
  endfunction

  task automatic test_reset();
    logic [7:0] o;
    rst = 1'b1;
    bus.enable = 1'b1;
    bus.MOUSE_LEFT = 1'b1;
    bus.peer_connect_in = 1'b1;
    set_pos(300, 250);
    for (int i = 0; i < 3; i++) begin
      step();
      o = all_outs();
      checks++;
      if (o !== 8'h00) begin
        failures++;
        $display("FAIL reset_outs cycle %0d: got %b expected 00000000", i, o);
      end
    end
    rst = 1'b0;
    bus.MOUSE_LEFT = 1'b0;
    bus.peer_connect_in = 1'b0;
    set_pos(10, 10);
    step();
    step();
  endtask

  task automatic test_hover();
    int tx[8]  = '{300, 300, 400, 239, 240, 399, 300, 300};
    int ty[8]  = '{250, 350, 250, 250, 240, 299, 300, 250};
    logic ten[8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    logic es[8]  = '{1, 0, 0, 0, 1, 1, 0, 0};
    logic ec[8]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    set_pos(300, 250);
    checks++;
    if (bus.mouse_on_start_button !== 1'b0) begin
      failures++;
      $display("FAIL hover_latency: got %b expected 0 before the edge", bus.mouse_on_start_button);
    end
    for (int i = 0; i < 8; i++) begin
      set_pos(tx[i], ty[i]);
      bus.enable = ten[i];
      step();
      checks++;
      if (bus.mouse_on_start_button !== es[i] || bus.mouse_on_connect_button !== ec[i]) begin
        failures++;
        $display("FAIL hover (%0d,%0d) en=%b: got start=%b conn=%b expected start=%b conn=%b",
                 tx[i], ty[i], ten[i], bus.mouse_on_start_button,
                 bus.mouse_on_connect_button, es[i], ec[i]);
      end
    end
    bus.enable = 1'b1;
  endtask

  task automatic test_click();
    int pulses;
    set_pos(300, 250);
    step();
    bus.MOUSE_LEFT = 1'b1;
    step();
    checks++;
    if (bus.start_game !== 1'b0) begin
      failures++;
      $display("FAIL click_on_press: start_game=%b expected 0", bus.start_game);
    end
    bus.MOUSE_LEFT = 1'b0;
    step();
    checks++;
    if (bus.start_game !== 1'b1 || bus.start_multi !== 1'b0) begin
      failures++;
      $display("FAIL click_pulse: start_game=%b start_multi=%b expected 1 0",
               bus.start_game, bus.start_multi);
    end
    step();
    checks++;
    if (bus.start_game !== 1'b0) begin
      failures++;
      $display("FAIL click_one_cycle: start_game=%b expected 0", bus.start_game);
    end
    // Press on the button, slide off, release: no click.
    pulses = 0;
    bus.MOUSE_LEFT = 1'b1;
    step();
    set_pos(10, 10);
    step();
    bus.MOUSE_LEFT = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      pulses += int'(bus.start_game);
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL click_slide_off: pulses=%0d expected 0", pulses);
    end
    // Press off the button, slide on, release: no click.
    pulses = 0;
    bus.MOUSE_LEFT = 1'b1;
    step();
    set_pos(300, 250);
    step();
    step();
    bus.MOUSE_LEFT = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      pulses += int'(bus.start_game);
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL click_slide_on: pulses=%0d expected 0", pulses);
    end
  endtask

  task automatic test_handshake();
    set_pos(300, 350);
    step();
    press_release();
    step();
    checks++;
    if (bus.send_connect !== 1'b1 || bus.peer_connect_out !== 1'b1) begin
      failures++;
      $display("FAIL hs_send: send=%b out=%b expected 1 1", bus.send_connect, bus.peer_connect_out);
    end
    bus.peer_connect_in = 1'b1;
    for (int i = 0; i < DEB + 1; i++) step();
    checks++;
    if (bus.receive_connect !== 1'b0) begin
      failures++;
      $display("FAIL hs_deb_early: receive=%b expected 0", bus.receive_connect);
    end
    step();
    checks++;
    if (bus.receive_connect !== 1'b1 || bus.connected !== 1'b0) begin
      failures++;
      $display("FAIL hs_deb_rise: receive=%b connected=%b expected 1 0",
               bus.receive_connect, bus.connected);
    end
    step();
    checks++;
    if (bus.connected !== 1'b1) begin
      failures++;
      $display("FAIL hs_connected: connected=%b expected 1", bus.connected);
    end
  endtask

  task automatic test_glitch_drop();
    int drops = 0;
    bus.peer_connect_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      drops += int'(!bus.connected);
    end
    bus.peer_connect_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      drops += int'(!bus.connected);
    end
    checks++;
    if (drops != 0) begin
      failures++;
      $display("FAIL glitch_hold: cycles disconnected=%0d expected 0", drops);
    end
    bus.peer_connect_in = 1'b0;
    for (int i = 0; i < DEB + 1; i++) step();
    checks++;
    if (bus.receive_connect !== 1'b1) begin
      failures++;
      $display("FAIL drop_early: receive=%b expected 1", bus.receive_connect);
    end
    step();
    step();
    checks++;
    if (bus.receive_connect !== 1'b0 || bus.send_connect !== 1'b1 || bus.connected !== 1'b0) begin
      failures++;
      $display("FAIL drop_req: receive=%b send=%b connected=%b expected 0 1 0",
               bus.receive_connect, bus.send_connect, bus.connected);
    end
  endtask

  task automatic test_priority();
    // Release lands on the same edge that the debounced peer request rises.
    for (int i = 0; i <= DEB + 1; i++) begin
      bus.peer_connect_in = 1'b1;
      bus.MOUSE_LEFT = (i >= 2 && i <= DEB);
      step();
    end
    checks++;
    if (bus.receive_connect !== 1'b1 || bus.send_connect !== 1'b1) begin
      failures++;
      $display("FAIL prio_align: receive=%b send=%b expected 1 1",
               bus.receive_connect, bus.send_connect);
    end
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (bus.send_connect !== 1'b0 || bus.peer_connect_out !== 1'b0 || bus.connected !== 1'b0) begin
      failures++;
      $display("FAIL prio_cancel: send=%b out=%b connected=%b expected 0 0 0",
               bus.send_connect, bus.peer_connect_out, bus.connected);
    end
    set_pos(300, 250);
    step();
    press_release();
    checks++;
    if (bus.start_game !== 1'b1 || bus.start_multi !== 1'b0) begin
      failures++;
      $display("FAIL prio_start: start_game=%b start_multi=%b expected 1 0",
               bus.start_game, bus.start_multi);
    end
  endtask

  task automatic test_linked_start();
    set_pos(300, 350);
    step();
    press_release();
    step();
    step();
    checks++;
    if (bus.connected !== 1'b1) begin
      failures++;
      $display("FAIL linked_again: connected=%b expected 1", bus.connected);
    end
    press_release();
    step();
    step();
    checks++;
    if (bus.send_connect !== 1'b1 || bus.connected !== 1'b1) begin
      failures++;
      $display("FAIL linked_ignore_click: send=%b connected=%b expected 1 1",
               bus.send_connect, bus.connected);
    end
    set_pos(300, 250);
    step();
    press_release();
    checks++;
    if (bus.start_game !== 1'b1 || bus.start_multi !== 1'b1) begin
      failures++;
      $display("FAIL linked_start_multi: start_game=%b start_multi=%b expected 1 1",
               bus.start_game, bus.start_multi);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] o;
    bus.MOUSE_LEFT = 1'b1;
    step();
    rst = 1'b1;
    step();
    o = all_outs();
    checks++;
    if (o !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid: got %b expected 00000000", o);
    end
    rst = 1'b0;
    bus.peer_connect_in = 1'b0;
    bus.MOUSE_LEFT = 1'b0;
    step();
    step();
    checks++;
    if (bus.start_game !== 1'b0 || bus.send_connect !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_release: start_game=%b send=%b expected 0 0",
               bus.start_game, bus.send_connect);
    end
  endtask

  task automatic test_random();
    logic ml_a[0:NR];
    logic en_a[0:NR];
    logic hs_a[0:NR];
    logic hc_a[0:NR];
    int   press_edge = 0;
    int   x = 10, y = 10;
    logic ml = 1'b0, en = 1'b1;
    logic ok_s, ok_c, clk_s, clk_c, prev_clk_c = 1'b0, send_m = 1'b0;
    rst = 1'b1;
    bus.peer_connect_in = 1'b0;
    bus.MOUSE_LEFT = 1'b0;
    bus.enable = 1'b0;
    step();
    rst = 1'b0;
    step();
    ml_a[0] = 1'b0; en_a[0] = 1'b0; hs_a[0] = 1'b0; hc_a[0] = 1'b0;
    for (int e = 1; e <= NR; e++) begin
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(4))
          0: begin x = $urandom_range(SX1 - 1, SX0); y = $urandom_range(SY1 - 1, SY0); end
          1: begin x = $urandom_range(CX1 - 1, CX0); y = $urandom_range(CY1 - 1, CY0); end
          2: begin x = ($urandom_range(1) == 1) ? SX0 - 1 + 2 * $urandom_range(1) : SX1 - 1 + $urandom_range(1);
                   y = $urandom_range(CY1, SY0); end
          3: begin x = $urandom_range(SX1 - 1, SX0);
                   y = ($urandom_range(1) == 1) ? SY1 - 1 + $urandom_range(1) : CY0 - 1 + $urandom_range(1); end
          default: begin x = $urandom_range(639); y = $urandom_range(479); end
        endcase
      end
      if ($urandom_range(3) == 0) ml = ~ml;
      if (en) en = ($urandom_range(39) != 0);
      else    en = ($urandom_range(3) == 0);
      set_pos(x, y);
      bus.MOUSE_LEFT = ml;
      bus.enable = en;
      ml_a[e] = ml;
      en_a[e] = en;
      hs_a[e] = en && x >= SX0 && x < SX1 && y >= SY0 && y < SY1;
      hc_a[e] = en && x >= CX0 && x < CX1 && y >= CY0 && y < CY1;
      step();
      clk_s = 1'b0;
      clk_c = 1'b0;
      if (ml_a[e] && !ml_a[e-1]) press_edge = e;
      if (!ml_a[e] && ml_a[e-1]) begin
        ok_s = 1'b1;
        ok_c = 1'b1;
        for (int k = press_edge; k <= e; k++) begin
          ok_s = ok_s && hs_a[k-1] && en_a[k];
          ok_c = ok_c && hc_a[k-1] && en_a[k];
        end
        clk_s = ok_s;
        clk_c = ok_c;
      end
      if (prev_clk_c) send_m = ~send_m;
      prev_clk_c = clk_c;
      checks++;
      if (bus.mouse_on_start_button !== hs_a[e] || bus.mouse_on_connect_button !== hc_a[e]) begin
        failures++;
        $display("FAIL rand_hover edge %0d: got %b%b expected %b%b", e,
                 bus.mouse_on_start_button, bus.mouse_on_connect_button, hs_a[e], hc_a[e]);
      end
      checks++;
      if (bus.start_game !== clk_s || bus.start_multi !== 1'b0) begin
        failures++;
        $display("FAIL rand_start edge %0d: start_game=%b start_multi=%b expected %b 0", e,
                 bus.start_game, bus.start_multi, clk_s);
      end
      checks++;
      if (bus.send_connect !== send_m) begin
        failures++;
        $display("FAIL rand_send edge %0d: send=%b expected %b", e, bus.send_connect, send_m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hover();
    test_click();
    test_handshake();
    test_glitch_drop();
    test_priority();
    test_linked_start();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
